trigger_readout: RTL and testbench
==================================

// Module: trigger_readout
// PURPOSE
//  Self-trigger and event readout for one PMT channel. Watches the ADC sample stream being written into the
//  ringbuffer, detects a rising threshold crossing, waits for the post-trigger samples to land, then reads a
//  window of PRE+POST samples back out of the ringbuffer (via its ain/rd_en/dout/aout ports) and streams them
//  downstream as one framed packet with a valid/ready handshake.
// PARAMETERS
//  SIZE   12  ringbuffer address width; buffer depth = 2**SIZE words, all address arithmetic modulo 2**SIZE
//  WIDTH  14  ADC sample width
//  PRE    16  samples before the trigger sample included in a frame
//  POST   48  samples from the trigger sample onward (trigger sample included); PRE+POST < 2**SIZE
// PORTS
//  sysclk     in   1      system clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  arm        in   1      level; triggers accepted only while high
//  threshold  in   WIDTH  unsigned trigger threshold, sampled on the trigger cycle
//  adc_din    in   WIDTH  sample being written to ringbuffer (same net as ringbuffer din)
//  adc_wr_en  in   1      write strobe to ringbuffer (same net as ringbuffer wr_en)
//  rb_waddr   in   SIZE   ringbuffer aout: address adc_din is written to this cycle
//  rb_raddr   out  SIZE   ringbuffer ain
//  rb_rd_en   out  1      ringbuffer rd_en
//  rb_rdata   in   WIDTH  ringbuffer dout
//  out_data   out  WIDTH  frame sample
//  out_valid  out  1      out_data valid; held with data stable until out_ready
//  out_ready  in   1      downstream accept; transfer when out_valid&&out_ready
//  out_sop    out  1      first word of frame (qualified by out_valid)
//  out_eop    out  1      last word of frame
//  out_err    out  1      frame overrun flag, valid with out_eop
//  busy       out  1      high in any state except IDLE
//  trig_count out  16     accepted triggers since reset, wraps at 2**16
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (rb_raddr, out_data, trig_count included); prev-sample reg 0; fill count 0.
//  - Pre-fill: fill counter counts adc_wr_en up to PRE (saturating); no trigger until fill == PRE.
//  - Trigger (IDLE only): adc_wr_en && arm && fill==PRE && prev <= threshold && adc_din > threshold (unsigned).
//    prev updates on every adc_wr_en, in every state. On trigger: trig_addr <= rb_waddr;
//    rd_ptr <= rb_waddr - PRE (mod 2**SIZE); post_cnt <= 1; trig_count++; go POST_WAIT.
//  - Triggers in any state other than IDLE are ignored (no queueing, no trig_count increment).
//  - POST_WAIT: post_cnt++ per adc_wr_en; when post_cnt == POST -> RD_ADDR. If POST==1 go RD_ADDR directly.
//  - Read sequence per word, ringbuffer read latency = 2 cycles (address registered, then data registered):
//    RD_ADDR  rb_raddr=rd_ptr, rb_rd_en=1
//    RD_WAIT  rb_rd_en=1 (rb_raddr held)
//    RD_CAP   rb_rd_en=0; out_data <= rb_rdata; sop/eop/err computed
//    PRESENT  out_valid=1; on out_ready: rd_ptr++ (wraps), word_cnt++;
//             last word -> IDLE, else -> RD_ADDR. Min 4 cycles/word.
//  - out_sop=1 for word_cnt==0; out_eop=1 for word_cnt==PRE+POST-1; frame always exactly PRE+POST words.
//  - Overrun: ovr_cnt counts adc_wr_en from trigger; reaching 2**SIZE-PRE before the last word is captured
//    means the writer overwrote unread data -> sticky err for this frame, reported as out_err on eop word;
//    frame still completes. err clears on next trigger.
//  - Wrap-around: trigger near address 0 reads e.g. 4092..4095,0..; no special casing beyond mod arithmetic.
//  - arm deassert after trigger does not abort the frame. rst mid-frame: immediate return to IDLE,
//    out_valid drops same edge, partial frame is not completed; fill restarts at 0.
//  - out_data/sop/eop/err must not change while out_valid && !out_ready.
// STRUCTURE
//  - Shared package: state encoding localparams (IDLE, POST_WAIT, RD_ADDR, RD_WAIT, RD_CAP, PRESENT), RB_RD_LAT=2.
//  - Sub-module: trig_detect (prev-sample register, fill counter, crossing compare); FSM and counters in top.
// TESTING
//  1. Ramp 0..4095 at thr=100, arm=1, out_ready=1: one trigger at sample 101 (addr 101); frame of 64 words =
//     85..148, sop on 85, eop on 148, err=0, trig_count=1.
//  2. Trigger with rb_waddr=4090: frame reads 4074..4095 then 0..41, values match those written, no gap.
//  3. Second crossing during POST_WAIT/readout: ignored; trig_count stays 1; after IDLE, next crossing accepted.
//  4. out_ready held 0 for 20 cycles on word 5: out_valid stays 1, out_data stable, no rd_en pulses.
//  5. Crossing within first 15 samples after rst: no trigger; busy=0.
//  6. out_ready=0 for 5000 writes mid-frame: out_err=1 on eop; rst mid-frame: next cycle out_valid=0, busy=0.

Source files
------------

// File: rtl/trigger_readout_pkg.sv
// Shared definitions for the PMT self-trigger readout: FSM state encoding and ringbuffer timing.
package trigger_readout_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] POST_WAIT = 3'd1;
    localparam logic [2:0] RD_ADDR   = 3'd2;
    localparam logic [2:0] RD_WAIT   = 3'd3;
    localparam logic [2:0] RD_CAP    = 3'd4;
    localparam logic [2:0] PRESENT   = 3'd5;

    typedef enum logic [2:0] {
        StIdle     = IDLE,
        StPostWait = POST_WAIT,
        StRdAddr   = RD_ADDR,
        StRdWait   = RD_WAIT,
        StRdCap    = RD_CAP,
        StPresent  = PRESENT
    } state_e;

    // Address register plus data register inside the ringbuffer; RD_ADDR/RD_WAIT cover it.
    localparam int unsigned RB_RD_LAT = 2;

endpackage

// File: rtl/trigger_readout_if.sv
// Framed sample stream leaving the trigger readout (valid/ready with sop/eop/err sidebands).
interface trigger_readout_if #(
    parameter int unsigned WIDTH = 14
) ();

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sop;
    logic             out_eop;
    logic             out_err;

    modport master (
        output out_data, out_valid, out_sop, out_eop, out_err,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_sop, out_eop, out_err,
        output out_ready
    );

endinterface

// File: rtl/trigger_readout_trig_detect.sv
// Rising threshold-crossing detector: previous-sample register, pre-fill counter, unsigned compare.
module trigger_readout_trig_detect #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned PRE   = 16
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             arm,
    input  logic [WIDTH-1:0] threshold,
    input  logic [WIDTH-1:0] adc_din,
    input  logic             adc_wr_en,
    output logic             crossing
);

    localparam int unsigned FW = (PRE > 0) ? $clog2(PRE + 1) : 1;

    logic [FW-1:0]    fill_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            fill_q <= '0;
            prev_q <= '0;
        end else if (adc_wr_en) begin
            prev_q <= adc_din;
            if (fill_q != FW'(PRE)) begin
                fill_q <= fill_q + FW'(1);
            end
        end
    end

    // Buffer must hold PRE valid samples before a crossing can open a frame.
    assign crossing = adc_wr_en && arm && (fill_q == FW'(PRE)) &&
                      (prev_q <= threshold) && (adc_din > threshold);

endmodule

// File: rtl/trigger_readout.sv
// Self-trigger and ringbuffer readout for one PMT channel: captures PRE+POST samples around a
// rising threshold crossing and streams them out as one framed packet.
module trigger_readout
    import trigger_readout_pkg::*;
#(
    parameter int unsigned SIZE  = 12,
    parameter int unsigned WIDTH = 14,
    parameter int unsigned PRE   = 16,
    parameter int unsigned POST  = 48
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               arm,
    input  logic [WIDTH-1:0]   threshold,
    input  logic [WIDTH-1:0]   adc_din,
    input  logic               adc_wr_en,
    input  logic [SIZE-1:0]    rb_waddr,
    output logic [SIZE-1:0]    rb_raddr,
    output logic               rb_rd_en,
    input  logic [WIDTH-1:0]   rb_rdata,
    trigger_readout_if.master  stream,
    output logic               busy,
    output logic [15:0]        trig_count
);

    localparam int unsigned FRAME = PRE + POST;
    localparam int unsigned WCW   = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int unsigned PCW   = $clog2(POST + 1);

    localparam logic [WCW-1:0]  LAST_WORD = WCW'(FRAME - 1);
    localparam logic [SIZE-1:0] OVR_LIMIT = SIZE'((2 ** SIZE) - PRE);

    state_e           state_q, state_d;
    logic [SIZE-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PCW-1:0]   post_cnt_q, post_cnt_d;
    logic [WCW-1:0]   word_cnt_q, word_cnt_d;
    logic [SIZE-1:0]  ovr_cnt_q, ovr_cnt_d;
    logic             err_q, err_d;
    logic [15:0]      trig_count_q, trig_count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             oerr_q, oerr_d;
    logic             crossing;

    trigger_readout_trig_detect #(
        .WIDTH (WIDTH),
        .PRE   (PRE)
    ) u_trig_detect (
        .sysclk    (sysclk),
        .rst       (rst),
        .arm       (arm),
        .threshold (threshold),
        .adc_din   (adc_din),
        .adc_wr_en (adc_wr_en),
        .crossing  (crossing)
    );

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        post_cnt_d   = post_cnt_q;
        word_cnt_d   = word_cnt_q;
        ovr_cnt_d    = ovr_cnt_q;
        err_d        = err_q;
        trig_count_d = trig_count_q;
        data_d       = data_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        oerr_d       = oerr_q;
        rb_rd_en     = 1'b0;

        // Writer has lapped the oldest frame sample once OVR_LIMIT writes follow the trigger.
        if (state_q != StIdle) begin
            if (adc_wr_en && (ovr_cnt_q != OVR_LIMIT)) begin
                ovr_cnt_d = ovr_cnt_q + SIZE'(1);
            end
            if (ovr_cnt_q == OVR_LIMIT) begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (crossing) begin
                    rd_ptr_d     = rb_waddr - SIZE'(PRE);
                    post_cnt_d   = PCW'(1);
                    word_cnt_d   = '0;
                    ovr_cnt_d    = '0;
                    err_d        = 1'b0;
                    trig_count_d = trig_count_q + 16'd1;
                    state_d      = (POST == 1) ? StRdAddr : StPostWait;
                end
            end
            StPostWait: begin
                if (post_cnt_q == PCW'(POST)) begin
                    state_d = StRdAddr;
                end else if (adc_wr_en) begin
                    post_cnt_d = post_cnt_q + PCW'(1);
                end
            end
            StRdAddr: begin
                rb_rd_en = 1'b1;
                state_d  = StRdWait;
            end
            StRdWait: begin
                rb_rd_en = 1'b1;
                state_d  = StRdCap;
            end
            StRdCap: begin
                data_d  = rb_rdata;
                sop_d   = (word_cnt_q == '0);
                eop_d   = (word_cnt_q == LAST_WORD);
                oerr_d  = (word_cnt_q == LAST_WORD) && err_q;
                state_d = StPresent;
            end
            StPresent: begin
                if (stream.out_ready) begin
                    rd_ptr_d   = rd_ptr_q + SIZE'(1);
                    word_cnt_d = word_cnt_q + WCW'(1);
                    state_d    = (word_cnt_q == LAST_WORD) ? StIdle : StRdAddr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q      <= StIdle;
            rd_ptr_q     <= '0;
            post_cnt_q   <= '0;
            word_cnt_q   <= '0;
            ovr_cnt_q    <= '0;
            err_q        <= 1'b0;
            trig_count_q <= '0;
            data_q       <= '0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            oerr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            post_cnt_q   <= post_cnt_d;
            word_cnt_q   <= word_cnt_d;
            ovr_cnt_q    <= ovr_cnt_d;
            err_q        <= err_d;
            trig_count_q <= trig_count_d;
            data_q       <= data_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            oerr_q       <= oerr_d;
        end
    end

    assign rb_raddr         = rd_ptr_q;
    assign busy             = (state_q != StIdle);
    assign trig_count       = trig_count_q;
    assign stream.out_valid = (state_q == StPresent);
    assign stream.out_data  = data_q;
    assign stream.out_sop   = sop_q;
    assign stream.out_eop   = eop_q;
    assign stream.out_err   = oerr_q;

endmodule

// File: tb/tb_trigger_readout.sv
// Randomized scoreboard bench for trigger_readout: sample-history reference model, ringbuffer model,
// and a decoupled stream monitor.
module tb_trigger_readout;

    localparam int SIZE  = 12;
    localparam int WIDTH = 14;
    localparam int PRE   = 16;
    localparam int POST  = 48;
    localparam int FRAME = PRE + POST;
    localparam int DEPTH = 1 << SIZE;
    localparam int LIMIT = DEPTH - PRE;

    logic             sysclk = 1'b0;
    logic             rst;
    logic             arm;
    logic [WIDTH-1:0] threshold;
    logic [WIDTH-1:0] adc_din;
    logic             adc_wr_en;
    logic [SIZE-1:0]  rb_waddr;
    logic [SIZE-1:0]  rb_raddr;
    logic             rb_rd_en;
    logic [WIDTH-1:0] rb_rdata;
    logic             busy;
    logic [15:0]      trig_count;

    trigger_readout_if #(.WIDTH(WIDTH)) sif ();

    trigger_readout #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH),
        .PRE   (PRE),
        .POST  (POST)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .arm        (arm),
        .threshold  (threshold),
        .adc_din    (adc_din),
        .adc_wr_en  (adc_wr_en),
        .rb_waddr   (rb_waddr),
        .rb_raddr   (rb_raddr),
        .rb_rd_en   (rb_rd_en),
        .rb_rdata   (rb_rdata),
        .stream     (sif),
        .busy       (busy),
        .trig_count (trig_count)
    );

    always #5 sysclk = ~sysclk;

    // Ringbuffer: registered address, then registered data (two-cycle read).
    logic [WIDTH-1:0] mem [DEPTH];
    logic [SIZE-1:0]  ra_q;
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ra_q     = '0;
        rb_rdata = '0;
    end
    always @(posedge sysclk) begin
        if (adc_wr_en) mem[rb_waddr] <= adc_din;
        if (rb_rd_en) begin
            ra_q     <= rb_raddr;
            rb_rdata <= mem[ra_q];
        end
    end

    int checks = 0;
    int errors = 0;
    int hist[$];
    int frame_q[$];
    int nwr = 0;
    int mprev = 0;
    int mtrig = 0;
    bit model_busy = 0;
    int wptr = 0;
    int mon_idx = 0;
    int mon_trig = 0;
    bit mon_have = 0;
    int frames_done = 0;
    int last_sop_data = -1;
    int last_eop_data = -1;
    int last_eop_err = -1;
    bit ready_rand = 0;
    int stall_word = 0;
    int stall_len = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle of ADC traffic; the model decides trigger acceptance from the rules directly.
    task automatic wr(input bit en, input int d);
        @(posedge sysclk); #1;
        chk("busy", busy, model_busy);
        chk("trig_count", trig_count, mtrig & 16'hffff);
        adc_wr_en = en;
        adc_din   = d[WIDTH-1:0];
        rb_waddr  = wptr[SIZE-1:0];
        if (en) begin
            if (arm && nwr >= PRE && mprev <= int'(threshold) && d > int'(threshold) && !model_busy)
            begin
                frame_q.push_back(hist.size());
                model_busy = 1;
                mtrig++;
            end
            hist.push_back(d);
            mprev = d;
            nwr++;
            wptr = (wptr + 1) % DEPTH;
        end
    endtask

    task automatic do_reset();
        @(posedge sysclk); #1;
        rst = 1'b1;
        adc_wr_en = 1'b0;
        @(posedge sysclk); #1;
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", sif.out_data, 0);
        chk("rst_sop", sif.out_sop, 0);
        chk("rst_eop", sif.out_eop, 0);
        chk("rst_err", sif.out_err, 0);
        chk("rst_trig_count", trig_count, 0);
        chk("rst_raddr", rb_raddr, 0);
        chk("rst_rd_en", rb_rd_en, 0);
        rst = 1'b0;
        frame_q.delete();
        mon_idx = 0;
        model_busy = 0;
        nwr = 0;
        mprev = 0;
        mtrig = 0;
    endtask

    task automatic prime(input int n);
        for (int i = 0; i < n; i++) wr(1'b1, $urandom_range(0, int'(threshold)));
        wr(1'b1, int'(threshold) + 1 + $urandom_range(0, 100));
    endtask

    task automatic wait_idle(input int bound, input bit dense);
        int n = 0;
        while (model_busy && n < bound) begin
            wr(dense ? 1'b1 : ($urandom_range(0, 3) != 0), $urandom_range(0, int'(threshold)));
            n++;
        end
        if (model_busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: frame not completed within %0d cycles", bound);
        end
    endtask

    // Monitor: pops the expected frame on its first word and checks every accepted word.
    always @(negedge sysclk) begin
        if (!rst && sif.out_valid && sif.out_ready) begin
            int ws;
            if (mon_idx == 0) begin
                mon_have = (frame_q.size() != 0);
                if (mon_have) mon_trig = frame_q.pop_front();
                else begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got sop word %0d, expected none", sif.out_data);
                end
            end
            if (mon_have) begin
                ws = hist.size() - 1 - mon_trig;
                if (ws < LIMIT) chk("data", sif.out_data, hist[mon_trig - PRE + mon_idx]);
                chk("sop", sif.out_sop, mon_idx == 0);
                chk("eop", sif.out_eop, mon_idx == FRAME - 1);
                if (mon_idx == 0) last_sop_data = int'(sif.out_data);
                if (mon_idx == FRAME - 1) begin
                    chk("err", sif.out_err, ws >= LIMIT);
                    last_eop_data = int'(sif.out_data);
                    last_eop_err  = int'(sif.out_err);
                end
            end
            if (mon_idx == FRAME - 1) begin
                mon_idx = 0;
                model_busy = 0;
                frames_done++;
            end else begin
                mon_idx++;
            end
        end
    end

    // Downstream ready: always-on, random, or a one-shot stall on a chosen word.
    initial begin
        sif.out_ready = 1'b1;
        forever begin
            @(posedge sysclk); #1;
            if (stall_len > 0 && sif.out_valid && mon_idx == stall_word) begin
                logic [WIDTH-1:0] held;
                logic             hsop;
                logic             heop;
                int               n;
                sif.out_ready = 1'b0;
                held = sif.out_data;
                hsop = sif.out_sop;
                heop = sif.out_eop;
                n = stall_len;
                stall_len = 0;
                repeat (n) begin
                    @(posedge sysclk); #1;
                    chk("stall_valid", sif.out_valid, 1);
                    chk("stall_data", sif.out_data, held);
                    chk("stall_sop", sif.out_sop, hsop);
                    chk("stall_eop", sif.out_eop, heop);
                    chk("stall_rd_en", rb_rd_en, 0);
                end
            end else begin
                sif.out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0;
        rst = 1'b1;
        arm = 1'b0;
        threshold = 14'd100;
        adc_din = '0;
        adc_wr_en = 1'b0;
        rb_waddr = '0;
        do_reset();

        // Crossings before the pre-fill completes must not trigger.
        arm = 1'b1;
        for (int i = 0; i < PRE - 1; i++) wr(1'b1, (i % 2) ? 200 : 0);
        wr(1'b0, 0);
        chk("prefill_busy", busy, 0);
        chk("prefill_count", trig_count, 0);

        // Ramp: single trigger at sample 101, frame 85..148.
        do_reset();
        wptr = 0;
        f0 = frames_done;
        for (int i = 0; i < 500; i++) wr(1'b1, i);
        wait_idle(2000, 1'b0);
        chk("ramp_frames", frames_done - f0, 1);
        chk("ramp_sop_word", last_sop_data, 85);
        chk("ramp_eop_word", last_eop_data, 148);
        chk("ramp_eop_err", last_eop_err, 0);
        chk("ramp_count", trig_count, 1);

        // Trigger at address 4090: read wraps from 4095 to 0.
        do_reset();
        ready_rand = 1;
        threshold = 14'($urandom_range(1000, 8000));
        wptr = 4090 - 20;
        f0 = frames_done;
        prime(20);
        wait_idle(5000, 1'b0);
        chk("wrap_frames", frames_done - f0, 1);

        // Random crossings while busy are ignored; crossings after idle are accepted.
        do_reset();
        threshold = 14'd5000;
        for (int i = 0; i < 1500; i++) begin
            wr($urandom_range(0, 3) != 0,
               $urandom_range(0, 1) ? $urandom_range(0, 5000) : $urandom_range(5001, 16383));
        end
        wait_idle(5000, 1'b0);

        // 20-cycle backpressure on word 5.
        do_reset();
        ready_rand = 0;
        threshold = 14'd300;
        stall_word = 5;
        stall_len = 20;
        prime(20);
        wait_idle(3000, 1'b0);
        chk("stall_consumed", stall_len, 0);

        // Long stall lets the writer lap the frame: err on eop, frame still completes.
        do_reset();
        threshold = 14'd100;
        stall_word = 5;
        stall_len = 5000;
        f0 = frames_done;
        prime(20);
        wait_idle(8000, 1'b1);
        chk("ovr_frames", frames_done - f0, 1);
        chk("ovr_eop_err", last_eop_err, 1);

        // Reset in the middle of a readout.
        prime(20);
        begin
            int n = 0;
            while (mon_idx < 10 && n < 2000) begin
                wr(1'b1, $urandom_range(0, 100));
                n++;
            end
            chk("midframe_reached", mon_idx >= 10, 1);
        end
        do_reset();
        for (int i = 0; i < 8; i++) wr(1'b1, $urandom_range(0, 100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
